huffman_decoder: RTL and testbench

- Streaming Huffman decoder for 4-bit symbols, such as quantized weight indices.
- Works on a 6-bit look-ahead window of the encoded bitstream, supplied by an upstream bit-feeder.
- For each symbol it reports the decoded value and the number of bits consumed. The feeder shifts that many new bits into the window and returns it with `load`.
- Sits between the compressed-stream fetch logic and the weight/activation unpacker.

---
 rtl/huffman_decoder.sv | 119 +++++++++++
 tb/tb_huffman_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/huffman_decoder.sv
// huffman_decoder
//   Streaming decoder for a fixed prefix-free code of 4-bit symbols. It looks at
//   a 6-bit window of the bitstream and returns the decoded symbol together with
//   the number of bits the upstream feeder must shift out. It sits between the
//   compressed-stream fetch logic and the weight/activation unpacker.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   encodedData  in   [5:0] bit window, bit 5 = oldest (next) stream bit
//   load         in   window has been refreshed by the feeder
//   ready        out  one-cycle request; decodedData/symbolLength valid while high
//   decodedData  out  [3:0] decoded symbol
//   symbolLength out  [3:0] bits consumed: 1, 4, 5, 6 or 10 (escape)
//
// The first ready pulse after reset is a fill request. It carries no symbol.
module huffman_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] encodedData,
    input  logic       load,
    output logic       ready,
    output logic [3:0] decodedData,
    output logic [3:0] symbolLength
);

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       esc_q, esc_d;
    logic       ready_q, ready_d;
    logic [3:0] dec_q, dec_d;
    logic [3:0] len_q, len_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= REQ;
            esc_q   <= 1'b0;
            ready_q <= 1'b1;
            dec_q   <= 4'd0;
            len_q   <= 4'd6;
        end else begin
            state_q <= state_d;
            esc_q   <= esc_d;
            ready_q <= ready_d;
            dec_q   <= dec_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        esc_d   = esc_q;
        ready_d = ready_q;
        dec_d   = dec_q;
        len_d   = len_q;

        unique case (state_q)
            REQ: begin
                // The request lasts one cycle; a load seen here is ignored.
                ready_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (load) begin
                    ready_d = 1'b1;
                    state_d = REQ;
                    if (esc_q) begin
                        // Second half of an escape: 4 raw literal bits.
                        dec_d = encodedData[5:2];
                        len_d = 4'd4;
                        esc_d = 1'b0;
                    end else begin
                        casez (encodedData)
                            6'b1?????: begin
                                dec_d = 4'd0;
                                len_d = 4'd1;
                            end
                            6'b01????: begin
                                dec_d = 4'd1 + {2'b00, encodedData[3:2]};
                                len_d = 4'd4;
                            end
                            6'b001???: begin
                                dec_d = 4'd5 + {2'b00, encodedData[2:1]};
                                len_d = 4'd5;
                            end
                            6'b0001??: begin
                                dec_d = 4'd9 + {2'b00, encodedData[1:0]};
                                len_d = 4'd6;
                            end
                            6'b000000: begin
                                // Escape prefix: no symbol, keep the previous
                                // decodedData and take the literal next time.
                                len_d = 4'd10;
                                esc_d = 1'b1;
                            end
                            default: begin
                                // 000001/000010/000011 -> 13/14/15
                                dec_d = 4'd12 + {2'b00, encodedData[1:0]};
                                len_d = 4'd6;
                            end
                        endcase
                    end
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    assign ready        = ready_q;
    assign decodedData  = dec_q;
    assign symbolLength = len_q;

endmodule

// File: tb/tb_huffman_decoder.sv
module tb_huffman_decoder;

    logic       clk;
    logic       rst;
    logic [5:0] encodedData;
    logic       load;
    logic       ready;
    logic [3:0] decodedData;
    logic [3:0] symbolLength;

    int tests_run;
    int tests_failed;

    huffman_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .encodedData (encodedData),
        .load        (load),
        .ready       (ready),
        .decodedData (decodedData),
        .symbolLength(symbolLength)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] win;
        logic [3:0] exp_dec;
        logic [3:0] exp_len;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in WAIT. Presents one window with a
    // single-cycle load, checks the resulting ready pulse and the return to WAIT.
    task automatic feed(input logic [5:0] win, input logic [3:0] exp_dec,
                        input logic [3:0] exp_len, input string tag);
        encodedData = win;
        load        = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check({tag, " ready"}, int'(ready), 1);
        check({tag, " dec"}, int'(decodedData), int'(exp_dec));
        check({tag, " len"}, int'(symbolLength), int'(exp_len));
        $display("[TB] %s win=%b -> ready=%0d dec=%0d len=%0d (exp dec=%0d len=%0d)",
                 tag, win, ready, decodedData, symbolLength, exp_dec, exp_len);
        @(negedge clk);
        check({tag, " ready_drop"}, int'(ready), 0);
    endtask

    initial begin
        logic [3:0] hold_dec;
        logic [3:0] hold_len;

        tests_run    = 0;
        tests_failed = 0;
        load         = 1'b0;
        encodedData  = 6'b000000;

        // All-ones stream, every code class, then an escape sequence.
        vecs[0]  = '{6'b111111, 4'd0,  4'd1};
        vecs[1]  = '{6'b111111, 4'd0,  4'd1};
        vecs[2]  = '{6'b111111, 4'd0,  4'd1};
        vecs[3]  = '{6'b011000, 4'd3,  4'd4};
        vecs[4]  = '{6'b001010, 4'd6,  4'd5};
        vecs[5]  = '{6'b000111, 4'd12, 4'd6};
        vecs[6]  = '{6'b000011, 4'd15, 4'd6};
        vecs[7]  = '{6'b010000, 4'd1,  4'd4};
        vecs[8]  = '{6'b011111, 4'd4,  4'd4};
        vecs[9]  = '{6'b001000, 4'd5,  4'd5};
        vecs[10] = '{6'b001111, 4'd8,  4'd5};
        vecs[11] = '{6'b000100, 4'd9,  4'd6};
        vecs[12] = '{6'b000101, 4'd10, 4'd6};
        vecs[13] = '{6'b000001, 4'd13, 4'd6};
        vecs[14] = '{6'b000010, 4'd14, 4'd6};
        vecs[15] = '{6'b000011, 4'd15, 4'd6};
        vecs[16] = '{6'b000000, 4'd15, 4'd10}; // escape keeps previous symbol
        vecs[17] = '{6'b101010, 4'd10, 4'd4};  // raw literal 1010
        vecs[18] = '{6'b100000, 4'd0,  4'd1};
        vecs[19] = '{6'b000000, 4'd0,  4'd10}; // escape left pending for the reset test

        // Reset and the initial fill request.
        rst = 1'b0;
        #12;
        check("rst ready", int'(ready), 1);
        check("rst len", int'(symbolLength), 6);
        check("rst dec", int'(decodedData), 0);
        #8;
        rst = 1'b1;
        #1;
        check("fill ready", int'(ready), 1);
        check("fill len", int'(symbolLength), 6);
        check("fill dec", int'(decodedData), 0);
        @(negedge clk);
        check("fill drop", int'(ready), 0);

        for (int i = 0; i < 20; i++) begin
            feed(vecs[i].win, vecs[i].exp_dec, vecs[i].exp_len, $sformatf("vec%0d", i));
        end

        // Reset while an escape is pending: the next window must decode
        // as a normal code, not as a literal.
        rst = 1'b0;
        #1;
        check("areset ready", int'(ready), 1);
        check("areset len", int'(symbolLength), 6);
        check("areset dec", int'(decodedData), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst wait", int'(ready), 0);
        feed(6'b010011, 4'd1, 4'd4, "after_rst");

        // Long idle in WAIT: outputs frozen, then exactly one pulse.
        hold_dec = decodedData;
        hold_len = symbolLength;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d ready", i), int'(ready), 0);
            check($sformatf("idle%0d dec", i), int'(decodedData), int'(hold_dec));
            check($sformatf("idle%0d len", i), int'(symbolLength), int'(hold_len));
        end
        feed(6'b001100, 4'd7, 4'd5, "idle_load");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("single_pulse%0d", i), int'(ready), 0);
        end

        // load held high: the one in REQ must be ignored, giving a pulse
        // every second cycle.
        encodedData = 6'b111111;
        load        = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("cont%0d ready", i), int'(ready), (i % 2 == 0) ? 1 : 0);
            if (i % 2 == 0) begin
                check($sformatf("cont%0d dec", i), int'(decodedData), 0);
                check($sformatf("cont%0d len", i), int'(symbolLength), 1);
            end
            $display("[TB] cont%0d ready=%0d dec=%0d len=%0d", i, ready, decodedData, symbolLength);
        end
        load = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
